aes_subbytes_engine: RTL

Parametrised, multi-cycle SubBytes engine for the AES-256 datapath. It accepts one 128-bit state over a valid/ready handshake and substitutes all 16 bytes through the AES S-box, LANES bytes per cycle. It holds the result until the downstream round logic accepts it. It generalises the single combinational byte S-box with a lane count/area trade-off, a per-block forward/inverse mode, and flow control, and sits between AddRoundKey and ShiftRows in the round pipeline.

---
 rtl/aes_subbytes_engine.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/aes_subbytes_engine.sv
// Multi-cycle AES SubBytes engine: substitutes a 128-bit state LANES bytes per cycle
// behind valid/ready handshakes. Define SUBBYTES_INV_EN to build the inverse S-box path.

module aes_sbox_lane (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (bits 1..7 of the exponent); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef SUBBYTES_INV_EN
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  assign dout = inv ? gf_inv(inv_affine(din)) : fwd_affine(gf_inv(din));
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign dout = fwd_affine(gf_inv(din));
`endif

endmodule

module aes_subbytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("aes_subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [15:0][7:0]        wr, wr_nxt, res;
  logic                    mode;
  logic [LANES-1:0][7:0]   lane_in, lane_out;
  logic [4:0]              base;
  logic                    accept, last_grp, out_fire;

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_grp = (cnt == CW'(GROUPS - 1));
  assign base     = 5'(cnt) * 5'(LANES);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)   state_nxt = S_RUN;
      S_RUN:   if (last_grp) state_nxt = S_HOLD;
      S_HOLD:  if (out_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_HOLD);
    busy      = (state == S_RUN) || (state == S_HOLD);
  end

  // Lanes see the current group; only that group's bytes are rewritten.
  always_comb begin
    wr_nxt = wr;
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = wr[4'(base + 5'(l))];
      wr_nxt[4'(base + 5'(l))] = lane_out[l];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_lane u_sbox (
      .din  (lane_in[g]),
      .inv  (mode),
      .dout (lane_out[g])
    );
  end

  // res is a separate register so out_data keeps the last result once a new block starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr   <= '0;
      res  <= '0;
      mode <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          wr   <= in_data;
          mode <= in_inv;
          cnt  <= '0;
        end
        S_RUN: begin
          wr <= wr_nxt;
          if (last_grp) res <= wr_nxt;
          else          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = res;

endmodule
